// File: rtl/pcs_tx_code_group.sv
// 1000BASE-X PCS TX code-group generator: expands ordered-set requests into octet code-groups.
// Latency 1 cycle from handshake to first code-group; no backpressure, one code-group every cycle.
package pcs_tx_pkg;
   typedef enum logic [3:0] {
      OS_I  = 4'h0,
      OS_C  = 4'h1,
      OS_S  = 4'h2,
      OS_T  = 4'h3,
      OS_R  = 4'h4,
      OS_V  = 4'h5,
      OS_D  = 4'h6,
      OS_LI = 4'h7
   } ordered_set_t;
endpackage

module pcs_tx_code_group
   import pcs_tx_pkg::*;
#(
   parameter bit LPI_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  tx_o_set,
   input  logic [7:0]  txd,
   input  logic [15:0] tx_config_reg,
   input  logic        tx_disparity,
   output logic [7:0]  tx_code_group,
   output logic        tx_is_k,
   output logic        tx_even,
   output logic        tx_oset_indicate,
   output logic        tx_align_err
);

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [7:0] D_I1  = 8'hC5;
   localparam logic [7:0] D_I2  = 8'h50;
   localparam logic [7:0] D_LI1 = 8'hA6;
   localparam logic [7:0] D_LI2 = 8'h9A;
   localparam logic [7:0] D_C1  = 8'hB5;
   localparam logic [7:0] D_C2  = 8'h42;

   typedef enum logic [2:0] {
      ST_SINGLE,
      ST_K1,
      ST_CG2,
      ST_CG3,
      ST_CG4
   } state_t;

   state_t      state;
   logic [15:0] cfg_q;
   logic        disp_q;
   logic        is_cfg_q;
   logic        is_lpi_q;
   logic        c_toggle;

   logic        in_cfg;
   logic        in_lpi;
   logic        in_idle;
   logic        in_multi;
   logic [7:0]  single_cg;
   logic        single_k;
   logic [7:0]  second_cg;

   // Classify the request offered at the handshake edge.
   always_comb begin
      in_cfg    = (tx_o_set == OS_C);
      in_lpi    = LPI_EN && (tx_o_set == OS_LI);
      in_idle   = (tx_o_set == OS_I) || (!LPI_EN && (tx_o_set == OS_LI));
      in_multi  = in_cfg || in_lpi || in_idle;
      single_cg = K30_7;
      single_k  = 1'b1;
      case (tx_o_set)
         OS_S:    single_cg = K27_7;
         OS_T:    single_cg = K29_7;
         OS_R:    single_cg = K23_7;
         OS_D: begin
            single_cg = txd;
            single_k  = 1'b0;
         end
         default: single_cg = K30_7;
      endcase
   end

   // Second code-group of a multi-cg set uses only values latched at the handshake.
   always_comb begin
      second_cg = disp_q ? D_I1 : D_I2;
      if (is_cfg_q) begin
         second_cg = c_toggle ? D_C2 : D_C1;
      end else if (is_lpi_q) begin
         second_cg = disp_q ? D_LI1 : D_LI2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_SINGLE;
         tx_code_group    <= K28_5;
         tx_is_k          <= 1'b1;
         tx_even          <= 1'b0;
         tx_oset_indicate <= 1'b1;
         tx_align_err     <= 1'b0;
         c_toggle         <= 1'b0;
         cfg_q            <= 16'h0000;
         disp_q           <= 1'b0;
         is_cfg_q         <= 1'b0;
         is_lpi_q         <= 1'b0;
      end else begin
         tx_even      <= ~tx_even;
         tx_align_err <= 1'b0;
         if (tx_oset_indicate) begin
            cfg_q    <= tx_config_reg;
            disp_q   <= tx_disparity;
            is_cfg_q <= in_cfg;
            is_lpi_q <= in_lpi;
            if (!in_cfg) begin
               c_toggle <= 1'b0;
            end
            if (in_multi) begin
               state            <= ST_K1;
               tx_code_group    <= K28_5;
               tx_is_k          <= 1'b1;
               tx_oset_indicate <= 1'b0;
               // Current position even means the next one is odd: misaligned start.
               tx_align_err     <= tx_even;
            end else begin
               state            <= ST_SINGLE;
               tx_code_group    <= single_cg;
               tx_is_k          <= single_k;
               tx_oset_indicate <= 1'b1;
            end
         end else begin
            case (state)
               ST_K1: begin
                  state            <= ST_CG2;
                  tx_code_group    <= second_cg;
                  tx_is_k          <= 1'b0;
                  tx_oset_indicate <= !is_cfg_q;
               end
               ST_CG2: begin
                  state            <= ST_CG3;
                  tx_code_group    <= cfg_q[7:0];
                  tx_is_k          <= 1'b0;
                  tx_oset_indicate <= 1'b0;
               end
               ST_CG3: begin
                  state            <= ST_CG4;
                  tx_code_group    <= cfg_q[15:8];
                  tx_is_k          <= 1'b0;
                  tx_oset_indicate <= 1'b1;
                  c_toggle         <= ~c_toggle;
               end
               default: begin
                  state            <= ST_SINGLE;
                  tx_code_group    <= K30_7;
                  tx_is_k          <= 1'b1;
                  tx_oset_indicate <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pcs_tx_code_group.sv
// Directed bench for pcs_tx_code_group: each request pushes its expected code-groups to a
// scoreboard queue, popped and compared once per cycle as the DUT emits them.
module tb_pcs_tx_code_group;
   import pcs_tx_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  tx_o_set;
   logic [7:0]  txd;
   logic [15:0] tx_config_reg;
   logic        tx_disparity;
   logic [7:0]  tx_code_group;
   logic        tx_is_k;
   logic        tx_even;
   logic        tx_oset_indicate;
   logic        tx_align_err;

   always #5 clk = ~clk;

   pcs_tx_code_group #(.LPI_EN(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .tx_o_set         (tx_o_set),
      .txd              (txd),
      .tx_config_reg    (tx_config_reg),
      .tx_disparity     (tx_disparity),
      .tx_code_group    (tx_code_group),
      .tx_is_k          (tx_is_k),
      .tx_even          (tx_even),
      .tx_oset_indicate (tx_oset_indicate),
      .tx_align_err     (tx_align_err)
   );

   typedef struct packed {
      logic [7:0] cg;
      logic       k;
      logic       even;
      logic       oset;
      logic       align;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic m_even;
   logic m_tog;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".cg"},   tx_code_group,               8'hBC);
      chk({tag, ".k"},    {7'b0, tx_is_k},             8'h01);
      chk({tag, ".even"}, {7'b0, tx_even},             8'h00);
      chk({tag, ".oset"}, {7'b0, tx_oset_indicate},    8'h01);
      chk({tag, ".aerr"}, {7'b0, tx_align_err},        8'h00);
   endtask

   task automatic cycle_check(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s scoreboard empty observed=%h expected=none", tag, tx_code_group);
      end else begin
         e = sb.pop_front();
         chk({tag, ".cg"},   tx_code_group,            e.cg);
         chk({tag, ".k"},    {7'b0, tx_is_k},          {7'b0, e.k});
         chk({tag, ".even"}, {7'b0, tx_even},          {7'b0, e.even});
         chk({tag, ".oset"}, {7'b0, tx_oset_indicate}, {7'b0, e.oset});
         chk({tag, ".aerr"}, {7'b0, tx_align_err},     {7'b0, e.align});
      end
   endtask

   // Drive one request, predict its code-groups, then check n_run of them (0 = all).
   task automatic send(input logic [3:0] os, input logic [7:0] d, input logic [15:0] cfg,
                       input logic disp, input logic disp_late, input int n_run, input string tag);
      logic [7:0] cgs[4];
      logic       ks[4];
      int         n;
      int         stop;
      logic       aln;
      tx_o_set      = os;
      txd           = d;
      tx_config_reg = cfg;
      tx_disparity  = disp;
      n      = 2;
      cgs[0] = 8'hBC;
      cgs[1] = 8'h00;
      cgs[2] = cfg[7:0];
      cgs[3] = cfg[15:8];
      ks[0]  = 1'b1;
      ks[1]  = 1'b0;
      ks[2]  = 1'b0;
      ks[3]  = 1'b0;
      case (os)
         OS_I:  cgs[1] = disp ? 8'hC5 : 8'h50;
         OS_LI: cgs[1] = disp ? 8'hA6 : 8'h9A;
         OS_C: begin
            cgs[1] = m_tog ? 8'h42 : 8'hB5;
            n      = 4;
         end
         OS_S: begin n = 1; cgs[0] = 8'hFB; end
         OS_T: begin n = 1; cgs[0] = 8'hFD; end
         OS_R: begin n = 1; cgs[0] = 8'hF7; end
         OS_D: begin n = 1; cgs[0] = d; ks[0] = 1'b0; end
         default: begin n = 1; cgs[0] = 8'hFE; end
      endcase
      aln   = (n > 1) && m_even;
      m_tog = (os == OS_C) ? ~m_tog : 1'b0;
      for (int i = 0; i < n; i++) begin
         m_even = ~m_even;
         sb.push_back('{cgs[i], ks[i], m_even, (i == n - 1), ((i == 0) && aln)});
      end
      stop = (n_run == 0) ? n : n_run;
      for (int i = 0; i < stop; i++) begin
         cycle_check(tag);
         if (i == 0) begin
            tx_disparity  = disp_late;
            tx_o_set      = 4'hE;
            txd           = 8'h00;
            tx_config_reg = 16'hDEAD;
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      tx_o_set      = 4'h0;
      txd           = 8'h00;
      tx_config_reg = 16'h0000;
      tx_disparity  = 1'b0;
      m_even        = 1'b0;
      m_tog         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      @(negedge clk);
      rst = 1'b0;

      send(OS_I, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t1a");
      send(OS_I, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t1b");
      send(OS_I, 8'h00, 16'h0000, 1'b1, 1'b0, 0, "t2");
      send(OS_LI, 8'h00, 16'h0000, 1'b1, 1'b1, 0, "li1");
      send(OS_LI, 8'h00, 16'h0000, 1'b0, 1'b1, 0, "li2");

      send(OS_C, 8'h00, 16'h1234, 1'b0, 1'b0, 0, "t3a");
      send(OS_C, 8'h00, 16'h1234, 1'b0, 1'b0, 0, "t3b");
      send(OS_C, 8'h00, 16'h1234, 1'b0, 1'b0, 0, "t3c");

      send(OS_I, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t4i");
      send(OS_S, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t4s");
      send(OS_D, 8'hAA, 16'h0000, 1'b0, 1'b0, 0, "t4d1");
      send(OS_D, 8'h55, 16'h0000, 1'b0, 1'b0, 0, "t4d2");
      send(OS_T, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t4t");
      send(OS_R, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t4r1");
      send(OS_R, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t4r2");

      send(OS_S, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t5s");
      send(OS_I, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t5i");
      send(4'hA, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "t5v");

      send(OS_C, 8'h00, 16'h5678, 1'b0, 1'b0, 0, "t6a");
      send(OS_C, 8'h00, 16'h5678, 1'b0, 1'b0, 2, "t6b");
      rst = 1'b1;
      #1;
      check_reset("t6rst");
      sb.delete();
      m_even = 1'b0;
      m_tog  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send(OS_C, 8'h00, 16'hBEEF, 1'b0, 1'b0, 0, "t6c");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
